// File: rtl/ctrl_riesgos.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_riesgos
//  Purpose  : Hazard and stall controller for the 5-stage MIPS pipeline.
//             Drives PC / IF/ID / ID/EX / EX/MEM enables plus the IF/ID flush
//             and ID/EX bubble controls. Handles load-use hazards, jump
//             redirects and multi-cycle data-memory accesses (req/ack with a
//             timeout), and counts stall cycles for performance debug.
//  Ports    :
//    clk, rst_n            clock, synchronous active-low reset
//    id_rs, id_rt          source register fields of the ID instruction
//    id_use_rs, id_use_rt  ID instruction actually reads rs / rt
//    id_sel_dir            next-PC select from the decoder (00 = PC+4)
//    ex_memread, ex_rd     EX instruction is a load, and its destination
//    mem_req, mem_ack      data-memory access handshake in MEM
//    pc_en, ifid_en        PC and IF/ID load enables
//    ifid_flush            turn IF/ID into a NOP
//    idex_en, idex_bubble  ID/EX enable and control-field clear
//    exmem_en              EX/MEM and MEM/WB enable
//    mem_err               sticky memory-timeout flag
//    stall_cnt             saturating count of cycles with pc_en = 0
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_riesgos #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [1:0]       id_sel_dir,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    state_t             r_state;
    logic [7:0]         r_wcnt;
    logic               r_mem_err;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_frz;
    logic               w_lu;
    logic               w_jmp;
    logic               w_timeout;
    logic               w_freeze;

    // Raw memory-busy term; only meaningful while in RUN.
    assign w_frz = mem_req & ~mem_ack;

    // Load-use: the load in EX writes a register the ID instruction reads.
    // $zero is never a real dependency.
    assign w_lu  = ex_memread & (ex_rd != 5'd0) &
                   ((id_use_rs & (ex_rd == id_rs)) |
                    (id_use_rt & (ex_rd == id_rt)));

    assign w_jmp = (id_sel_dir != 2'b00);

    // Abort cycle: the access is considered finished, so the pipeline is
    // released and the ordinary load-use / jump rules take over.
    assign w_timeout = (r_state == ST_WAIT) & ~mem_ack & (r_wcnt == c_timeout);

    assign w_freeze = (r_state == ST_RUN) ? w_frz
                                          : (~mem_ack & ~w_timeout);

    // Output priority: reset, full freeze, load-use, jump, normal.
    // A jump that is also load-use stalls first; the flush waits until the
    // dependency clears on the following cycle.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_bubble = 1'b1;
            exmem_en    = 1'b0;
        end else if (w_freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
        end else if (w_lu) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (w_jmp) begin
            ifid_flush  = 1'b1;
        end
    end

    // Access FSM and wait counter. wcnt is loaded with 1 on the first freeze
    // cycle (spent in RUN) so that the abort lands after exactly
    // MEM_TIMEOUT frozen cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_wcnt    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_frz) begin
                        r_state <= ST_WAIT;
                        r_wcnt  <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        r_state <= ST_RUN;
                    end else if (w_timeout) begin
                        r_state   <= ST_RUN;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Saturating stall counter: counts every out-of-reset cycle with the PC held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_riesgos.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_riesgos
//  Purpose  : Self-checking bench for ctrl_riesgos. Two instances share the
//             stimulus: one with a short timeout (4) and a wide counter, one
//             with a long timeout (32) and a 4-bit counter. Directed
//             scenarios are followed by random traffic, all checked against
//             a cycle-level behavioural model of the controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_riesgos;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_memread, mem_req, mem_ack;
    logic [1:0] id_sel_dir;

    logic        pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_bubble_a, exmem_en_a, mem_err_a;
    logic [15:0] stall_cnt_a;
    logic        pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_bubble_b, exmem_en_b, mem_err_b;
    logic [3:0]  stall_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_riesgos #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_sel_dir(id_sel_dir), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a),
        .idex_en(idex_en_a), .idex_bubble(idex_bubble_a), .exmem_en(exmem_en_a),
        .mem_err(mem_err_a), .stall_cnt(stall_cnt_a)
    );

    ctrl_riesgos #(.MEM_TIMEOUT(32), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_sel_dir(id_sel_dir), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b),
        .idex_en(idex_en_b), .idex_bubble(idex_bubble_b), .exmem_en(exmem_en_b),
        .mem_err(mem_err_b), .stall_cnt(stall_cnt_b)
    );

    // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------
    int  m_tmo [2] = '{4, 32};
    int  m_max [2] = '{65535, 15};
    bit  m_wait[2];
    int  m_wcnt[2];
    bit  m_err [2];
    int  m_cnt [2];
    bit  m_known = 1'b0;   // counters undefined until the first reset edge

    // Expected {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en}
    function automatic logic [5:0] model_out(input int k);
        bit hold, lu, jmp;
        if (!rst_n) return 6'b001010;
        if (m_wait[k]) hold = !mem_ack && (m_wcnt[k] != m_tmo[k]);
        else           hold = mem_req && !mem_ack;
        lu  = ex_memread && ex_rd != 0 &&
              ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
        jmp = id_sel_dir != 2'b00;
        if (hold) return 6'b000000;
        if (lu)   return 6'b000111;
        if (jmp)  return 6'b111101;
        return 6'b110101;
    endfunction

    task automatic model_edge(input int k, input bit pc_stalled);
        if (!rst_n) begin
            m_wait[k] = 0; m_wcnt[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end else begin
            if (pc_stalled && m_cnt[k] < m_max[k]) m_cnt[k]++;
            if (!m_wait[k]) begin
                if (mem_req && !mem_ack) begin m_wait[k] = 1; m_wcnt[k] = 1; end
            end else if (mem_ack) begin
                m_wait[k] = 0;
            end else if (m_wcnt[k] == m_tmo[k]) begin
                m_wait[k] = 0; m_err[k] = 1;
            end else begin
                m_wcnt[k]++;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: inputs were set by the caller just after the previous
    // edge; compare mid-cycle, then advance the model across the edge.
    task automatic tick();
        logic [5:0] ea, eb;
        #2;
        ea = model_out(0);
        eb = model_out(1);
        chk("ctl_a", {26'd0, pc_en_a, ifid_en_a, ifid_flush_a, idex_en_a, idex_bubble_a, exmem_en_a}, {26'd0, ea});
        chk("ctl_b", {26'd0, pc_en_b, ifid_en_b, ifid_flush_b, idex_en_b, idex_bubble_b, exmem_en_b}, {26'd0, eb});
        if (m_known) begin
            chk("cnt_a", {16'd0, stall_cnt_a}, m_cnt[0]);
            chk("cnt_b", {28'd0, stall_cnt_b}, m_cnt[1]);
            chk("err_a", {31'd0, mem_err_a}, {31'd0, m_err[0]});
            chk("err_b", {31'd0, mem_err_b}, {31'd0, m_err[1]});
        end
        @(posedge clk);
        model_edge(0, !ea[5]);
        model_edge(1, !eb[5]);
        if (!rst_n) m_known = 1'b1;
        #1;
    endtask

    task automatic idle();
        rst_n = 1; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_sel_dir = 0; ex_memread = 0; ex_rd = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic do_reset();
        idle(); rst_n = 0; tick(); tick();
        idle(); tick();
    endtask

    initial begin
        idle();
        // Reset: row-1 outputs while low, clean state afterwards
        rst_n = 0; tick(); tick();
        idle(); tick();
        chk("rst_cnt", {16'd0, stall_cnt_a}, 32'd0);
        chk("rst_err", {31'd0, mem_err_a}, 32'd0);

        // Load-use, then the same with ex_rd = 0 (no hazard)
        do_reset();
        ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1; tick();
        idle(); tick();
        chk("lu_cnt", {16'd0, stall_cnt_a}, 32'd1);
        ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1; tick();
        idle(); tick();
        chk("lu0_cnt", {16'd0, stall_cnt_a}, 32'd1);

        // Jump alone, then jump combined with load-use (stall wins)
        id_sel_dir = 2'b01; tick();
        id_sel_dir = 2'b10; ex_memread = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1; tick();
        idle(); id_sel_dir = 2'b10; tick();
        idle(); tick();

        // Memory access acknowledged in its 4th cycle: 3 freeze cycles
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 3; i++) tick();
        mem_ack = 1; tick();
        idle(); tick();
        chk("mem_cnt", {16'd0, stall_cnt_a}, 32'd3);

        // Ack in the first cycle: no freeze
        mem_req = 1; mem_ack = 1; tick();
        idle(); tick();
        chk("ack0_cnt", {16'd0, stall_cnt_a}, 32'd3);

        // Timeout on dut_a (4 freeze cycles, then abort cycle)
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 5; i++) tick();
        idle(); tick();
        chk("tmo_err", {31'd0, mem_err_a}, 32'd1);
        chk("tmo_cnt", {16'd0, stall_cnt_a}, 32'd4);

        // Reset in the middle of WAIT
        mem_req = 1; tick(); tick();
        rst_n = 0; tick();
        idle(); tick();
        chk("rstw_err", {31'd0, mem_err_a}, 32'd0);
        chk("rstw_pc",  {31'd0, pc_en_a},   32'd1);

        // Saturation on dut_b: 20 frozen cycles with a 4-bit counter
        do_reset();
        mem_req = 1;
        for (int i = 0; i < 20; i++) tick();
        idle(); tick();
        chk("sat_cnt", {28'd0, stall_cnt_b}, 32'd15);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n      = ($urandom_range(0, 79) != 0);
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_use_rs  = 1'($urandom);
            id_use_rt  = 1'($urandom);
            id_sel_dir = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 3));
            mem_req    = ($urandom_range(0, 2) != 0);
            mem_ack    = ($urandom_range(0, 9) < 2);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
